// File: rtl/velocity_estimator.sv
// rtl/velocity_estimator.sv - windowed position-delta velocity estimator
// Optional overrun event counter enabled by macro VE_OVERRUN_COUNTER_EN.
module velocity_estimator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        VE_enable,
    input  logic [COUNTER_WIDTH-1:0]    VE_window,
    output logic                        VE_overrun,
`ifdef VE_OVERRUN_COUNTER_EN
    output logic [15:0]                 VE_overrun_count,
`endif
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                        state_q, state_d;
    logic [COUNTER_WIDTH-1:0]      cnt_q;
    logic [COUNTER_WIDTH-1:0]      w_lat_q;
    logic [AXIS_TDATA_WIDTH-1:0]   ref_q;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_q;
    logic                          tvalid_q;
    logic                          overrun_q;
    logic                          en_q;

    logic                          start, close, advance, abort;
    logic [COUNTER_WIDTH-1:0]      w_eff;
    logic                          win_last;
    logic                          en_rise;
    logic                          ovr_evt;

    assign w_eff    = (VE_window == '0) ? CNT_ONE : VE_window;
    assign win_last = ((cnt_q + CNT_ONE) == w_lat_q);
    assign en_rise  = VE_enable & ~en_q;
    // Stalled beat replaced by a new result: newest data wins, flag the loss.
    assign ovr_evt  = close & tvalid_q & ~M_AXIS_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (VE_enable && S_AXIS_tvalid) state_d = ST_RUN;
            ST_RUN:  if (!VE_enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        close   = 1'b0;
        advance = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: start = VE_enable & S_AXIS_tvalid;
            ST_RUN: begin
                if (!VE_enable) begin
                    abort = 1'b1;
                end else if (S_AXIS_tvalid) begin
                    close   = win_last;
                    advance = ~win_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q     <= '0;
            w_lat_q   <= CNT_ONE;
            ref_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            en_q <= VE_enable;
            // Window length is only re-latched at a boundary so a live change
            // never truncates or stretches the window in progress.
            if (start || close) begin
                ref_q   <= S_AXIS_tdata;
                cnt_q   <= '0;
                w_lat_q <= w_eff;
            end else if (advance) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (abort) begin
                cnt_q <= '0;
            end
            if (close) begin
                tdata_q <= S_AXIS_tdata - ref_q;
            end
            tvalid_q <= close | (tvalid_q & ~M_AXIS_tready);
            if (en_rise) overrun_q <= 1'b0;
            if (ovr_evt) overrun_q <= 1'b1;
        end
    end

`ifdef VE_OVERRUN_COUNTER_EN
    logic [15:0] ovr_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovr_cnt_q <= '0;
        end else if (ovr_evt) begin
            if (ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end else if (en_rise) begin
            ovr_cnt_q <= '0;
        end
    end

    assign VE_overrun_count = ovr_cnt_q;
`endif

    assign S_AXIS_tready = 1'b1;
    assign M_AXIS_tvalid = tvalid_q;
    assign M_AXIS_tdata  = tdata_q;
    assign VE_overrun    = overrun_q;

endmodule
